// File: rtl/mac_feeder_2x2.sv
// Operand scheduler for the 2x2 systolic MAC array: buffers A rows / B columns,
// then clears the accumulators, streams K beats, drains zeros and flags done.

module mac_feeder_lane #(
  parameter int DW   = 32,
  parameter int KMAX = 16,
  parameter int AW   = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [DW-1:0] wd,
  input  logic [AW-1:0] ra,
  output logic [DW-1:0] rd
);
  logic [DW-1:0] mem [KMAX];

  // Operand storage is not reset; contents survive a mid-run reset.
  always_ff @(posedge clk)
    if (we) mem[wa] <= wd;

  assign rd = mem[ra];
endmodule

module mac_feeder_2x2 #(
  parameter int DW    = 32,
  parameter int KMAX  = 16,
  parameter int AW    = 4,
  parameter int DRAIN = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ld_we,
  input  logic [1:0]    ld_lane,
  input  logic [AW-1:0] ld_idx,
  input  logic [DW-1:0] ld_data,
  input  logic          start,
  input  logic [AW:0]   k_len,
  output logic [DW-1:0] out_a0,
  output logic [DW-1:0] out_a1,
  output logic [DW-1:0] out_b0,
  output logic [DW-1:0] out_b1,
  output logic          mac_clr,
  output logic          busy,
  output logic          done,
  output logic          err
);
  localparam int NUM_LANES = 4;
  localparam logic [AW:0] KMAX_C  = (AW+1)'(KMAX);
  localparam logic [AW:0] DRAIN_C = (AW+1)'(DRAIN);

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_STREAM, S_DRAIN, S_DONE} state_t;

  state_t                         state;
  logic [AW:0]                    cnt, klen_q;
  logic [NUM_LANES-1:0][DW-1:0]   rd_data, out_q;
  logic                           k_ok;

  assign k_ok = (k_len != '0) && (k_len <= KMAX_C);

  // Lane order: 0=A row0, 1=A row1, 2=B col0, 3=B col1.
  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    mac_feeder_lane #(.DW(DW), .KMAX(KMAX), .AW(AW)) u_lane (
      .clk (clk),
      .we  (ld_we && state == S_IDLE && ld_lane == 2'(l)),
      .wa  (ld_idx),
      .wd  (ld_data),
      .ra  (cnt[AW-1:0]),
      .rd  (rd_data[l])
    );
  end

  // cnt doubles as the read index while streaming (one beat ahead of out_q)
  // and as the drain-cycle count; AW+1 bits so K=KMAX compares cleanly.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      out_q   <= '0;
      mac_clr <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      cnt     <= '0;
      klen_q  <= '0;
    end else begin
      mac_clr <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          if (k_ok) begin
            klen_q  <= k_len;
            cnt     <= '0;
            mac_clr <= 1'b1;
            busy    <= 1'b1;
            state   <= S_CLEAR;
          end else begin
            err <= 1'b1;
          end
        end
        S_CLEAR: begin
          out_q <= rd_data;
          cnt   <= (AW+1)'(1);
          state <= S_STREAM;
        end
        S_STREAM: begin
          if (cnt == klen_q) begin
            out_q <= '0;
            cnt   <= (AW+1)'(1);
            state <= S_DRAIN;
          end else begin
            out_q <= rd_data;
            cnt   <= cnt + 1'b1;
          end
        end
        S_DRAIN: begin
          if (cnt == DRAIN_C) begin
            done  <= 1'b1;
            cnt   <= '0;
            state <= S_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign out_a0 = out_q[0];
  assign out_a1 = out_q[1];
  assign out_b0 = out_q[2];
  assign out_b1 = out_q[3];
endmodule

// File: tb/tb_mac_feeder_2x2.sv
// Randomized + directed bench for mac_feeder_2x2 against a cycle-offset model
// derived from the start-relative timing rules.

module tb_mac_feeder_2x2;
  localparam int DW = 32, KMAX = 16, AW = 4, DRAIN = 3;

  logic          clk = 0, rst = 0, ld_we = 0, start = 0;
  logic [1:0]    ld_lane = '0;
  logic [AW-1:0] ld_idx = '0;
  logic [DW-1:0] ld_data = '0;
  logic [AW:0]   k_len = '0;
  logic [DW-1:0] out_a0, out_a1, out_b0, out_b1;
  logic          mac_clr, busy, done, err;

  mac_feeder_2x2 #(.DW(DW), .KMAX(KMAX), .AW(AW), .DRAIN(DRAIN)) dut (
    .clk(clk), .rst(rst), .ld_we(ld_we), .ld_lane(ld_lane), .ld_idx(ld_idx),
    .ld_data(ld_data), .start(start), .k_len(k_len),
    .out_a0(out_a0), .out_a1(out_a1), .out_b0(out_b0), .out_b1(out_b1),
    .mac_clr(mac_clr), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0;

  task automatic chk(input string nm, input logic [131:0] act, input logic [131:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  wire [131:0] actv = {busy, done, err, mac_clr, out_a0, out_a1, out_b0, out_b1};

  // Model: t = cycles since the accepted start (0 when idle).
  logic [DW-1:0] bank_m [4][KMAX];
  int t = 0, mk = 1;
  bit e_err = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      t = 0; e_err = 0;
    end else begin
      e_err = 0;
      if (t == 0) begin
        if (ld_we) bank_m[ld_lane][ld_idx] = ld_data;
        if (start) begin
          if (k_len >= 1 && k_len <= KMAX) begin mk = int'(k_len); t = 1; end
          else e_err = 1;
        end
      end else if (t == mk + 2 + DRAIN) t = 0;
      else t = t + 1;
    end
  end

  function automatic logic [131:0] expv();
    logic [131:0] v;
    v = '0;
    v[131] = (t != 0);
    v[130] = (t == mk + 2 + DRAIN);
    v[129] = e_err;
    v[128] = (t == 1);
    if (t >= 2 && t <= mk + 1)
      v[127:0] = {bank_m[0][t-2], bank_m[1][t-2], bank_m[2][t-2], bank_m[3][t-2]};
    return v;
  endfunction

  always @(negedge clk) begin
    chk("cycle", actv, expv());
    chk("err_busy_excl", {131'b0, err & busy}, 132'b0);
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic load(input int ln, input int ix, input logic [DW-1:0] d);
    ld_we = 1; ld_lane = ln[1:0]; ld_idx = ix[AW-1:0]; ld_data = d;
    step();
    ld_we = 0;
  endtask

  logic [131:0] rec [64];

  // Launch, record outputs per cycle (cycle 1 = first after the start edge).
  task automatic run(input int k, input bit wr_busy, input int rst_at, output int dcyc);
    start = 1; k_len = k[AW:0];
    step();
    start = 0;
    if (wr_busy) begin ld_we = 1; ld_lane = 0; ld_idx = 5; ld_data = 32'hDEAD; end
    dcyc = -1;
    for (int c = 1; c < 64; c++) begin
      @(negedge clk);
      rec[c] = actv;
      ld_we = 0;
      if (c == rst_at) begin
        #2 rst = 0;
        #1 chk("rst_immediate", actv, 132'b0);
        @(posedge clk); #1 rst = 1;
        return;
      end
      if (done) begin dcyc = c; break; end
    end
    step();
  endtask

  function automatic logic [DW-1:0] f(input logic [131:0] r, input int lane);
    return r[127 - 32*lane -: 32];
  endfunction

  int dc;

  initial begin
    rst = 0;
    repeat (3) step();
    chk("reset_state", actv, 132'b0);
    rst = 1;
    step();

    for (int l = 0; l < 4; l++)
      for (int i = 0; i < KMAX; i++) load(l, i, DW'(i));

    run(16, 0, 0, dc);
    chk("k16_done_cycle", 132'(dc), 132'd21);
    chk("k16_beat0", rec[2], {4'b1000, {4{32'd0}}});
    chk("k16_beat15", rec[17], {4'b1000, {4{32'd15}}});
    chk("k16_drain_first", rec[18], {4'b1000, 128'b0});
    chk("k16_drain_last", rec[20], {4'b1000, 128'b0});

    load(0, 0, 1); load(0, 1, 2); load(1, 0, 3); load(1, 1, 4);
    load(2, 0, 5); load(2, 1, 7); load(3, 0, 6); load(3, 1, 8);
    run(2, 0, 0, dc);
    chk("mm_done_cycle", 132'(dc), 132'd7);
    chk("mm_clr_cycle1", rec[1], {4'b1001, 128'b0});
    chk("mm_beat0", rec[2][127:0], {32'd1, 32'd3, 32'd5, 32'd6});
    chk("mm_beat1", rec[3][127:0], {32'd2, 32'd4, 32'd7, 32'd8});
    chk("o00", 132'(f(rec[2],0)*f(rec[2],2) + f(rec[3],0)*f(rec[3],2)), 132'd19);
    chk("o01", 132'(f(rec[2],0)*f(rec[2],3) + f(rec[3],0)*f(rec[3],3)), 132'd22);
    chk("o10", 132'(f(rec[2],1)*f(rec[2],2) + f(rec[3],1)*f(rec[3],2)), 132'd43);
    chk("o11", 132'(f(rec[2],1)*f(rec[2],3) + f(rec[3],1)*f(rec[3],3)), 132'd50);

    start = 1; k_len = 0; step(); start = 0;
    @(negedge clk); chk("err_k0", {129'b0, busy, err, mac_clr}, 132'b010);
    step();
    start = 1; k_len = 17; step(); start = 0;
    @(negedge clk); chk("err_k17", {129'b0, busy, err, mac_clr}, 132'b010);
    step();

    run(8, 1, 0, dc);
    run(8, 0, 0, dc);
    chk("busy_write_dropped", 132'(f(rec[7], 0)), 132'd5);

    run(8, 0, 5, dc);
    repeat (2) step();
    run(4, 0, 0, dc);
    chk("relaunch_done_cycle", 132'(dc), 132'd9);
    chk("relaunch_beat0", rec[2][127:0], {32'd1, 32'd3, 32'd5, 32'd6});
    chk("relaunch_beat3", rec[5][127:0], {4{32'd3}});

    ld_we = 1; ld_lane = 3; ld_idx = 0; ld_data = 32'hCAFEF00D;
    run(1, 0, 0, dc);
    chk("same_cycle_write", 132'(f(rec[2], 3)), 132'hCAFEF00D);
    chk("k1_done_cycle", 132'(dc), 132'd6);

    for (int n = 0; n < 3000; n++) begin
      ld_we   = ($urandom_range(0, 3) == 0);
      ld_lane = 2'($urandom_range(0, 3));
      ld_idx  = AW'($urandom_range(0, KMAX - 1));
      ld_data = $urandom;
      start   = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 7) == 0) k_len = ($urandom_range(0, 1) == 0) ? '0 : (AW+1)'($urandom_range(17, 31));
      else k_len = (AW+1)'($urandom_range(1, KMAX));
      if (n == 1500) begin
        #2 rst = 0; #1 rst = 1;
      end
      step();
    end
    ld_we = 0; start = 0;
    repeat (30) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end
endmodule
